// File: rtl/ysyx_25070198_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_25070198_lsu_pkg                                                |
// | Shared state, access-size and error encodings for the extended LSU.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ysyx_25070198_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25070198_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_25070198_lsu_align                                              |
// | Combinational lane shifting: store data/mask and load extract/extend.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ysyx_25070198_lsu_align
  import ysyx_25070198_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]  st_off,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [DATA_W-1:0] st_wdata_sh,
  output logic [LANES-1:0]  st_wmask,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_result
);

  logic [LANES-1:0]  w_mask_base;
  logic [DATA_W-1:0] w_ld_shift;
  logic [DATA_W-1:0] w_keep;
  logic              w_sign;

  always_comb begin
    w_mask_base = '1;
    case (st_size)
      SZ_B:    w_mask_base = LANES'(4'h1);
      SZ_H:    w_mask_base = LANES'(4'h3);
      SZ_W:    w_mask_base = LANES'(4'hF);
      default: w_mask_base = '1;
    endcase
  end

  assign st_wmask    = w_mask_base << st_off;
  assign st_wdata_sh = st_wdata << {st_off, 3'b000};
  assign w_ld_shift  = ld_rdata >> {ld_off, 3'b000};

  // w_keep selects the bits that come from memory; the rest are extension.
  always_comb begin
    w_keep = '1;
    w_sign = w_ld_shift[DATA_W-1];
    case (ld_size)
      SZ_B: begin
        w_keep = DATA_W'(8'hFF);
        w_sign = w_ld_shift[7];
      end
      SZ_H: begin
        w_keep = DATA_W'(16'hFFFF);
        w_sign = w_ld_shift[15];
      end
      SZ_W: begin
        w_keep = DATA_W'(32'hFFFF_FFFF);
        w_sign = w_ld_shift[31];
      end
      default: begin
        w_keep = '1;
        w_sign = w_ld_shift[DATA_W-1];
      end
    endcase
  end

  assign ld_result = (w_ld_shift & w_keep) | (~w_keep & {DATA_W{ld_signed & w_sign}});

endmodule
`default_nettype wire

// File: rtl/ysyx_25070198_lsu_ext.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_25070198_lsu_ext                                                |
// | Latching load/store unit between EXU and the SimpleBus data port.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ysyx_25070198_lsu_ext
  import ysyx_25070198_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  bus_reqValid,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_wen,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wmask,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_respValid,
  input  logic                  bus_respErr
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t        r_state;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [CNT_W-1:0]  r_cnt;

  logic [OFF_W-1:0]  w_req_off;
  logic [3:0]        w_bytes;
  logic              w_legal;
  logic              w_timeout;
  logic [DATA_W-1:0] w_st_wdata;
  logic [LANES-1:0]  w_st_wmask;
  logic [DATA_W-1:0] w_ld_result;

  assign req_ready = (r_state == ST_IDLE);
  assign w_req_off = req_addr[OFF_W-1:0];
  assign w_bytes   = size_bytes(req_size);
  assign w_legal   = (w_bytes <= 4'(LANES)) &&
                     ((w_req_off & OFF_W'(w_bytes - 4'd1)) == '0);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = (r_cnt == c_cnt_last);
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  ysyx_25070198_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .st_off      (w_req_off),
    .st_size     (req_size),
    .st_wdata    (req_wdata),
    .st_wdata_sh (w_st_wdata),
    .st_wmask    (w_st_wmask),
    .ld_off      (r_off),
    .ld_size     (r_size),
    .ld_signed   (r_signed),
    .ld_rdata    (bus_rdata),
    .ld_result   (w_ld_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_off        <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_cnt        <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= ERR_NONE;
      bus_reqValid <= 1'b0;
      bus_addr     <= '0;
      bus_wen      <= 1'b0;
      bus_wdata    <= '0;
      bus_wmask    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            r_off    <= w_req_off;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_cnt    <= '0;
            if (w_legal) begin
              r_state      <= ST_WAIT;
              bus_reqValid <= 1'b1;
              bus_addr     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              bus_wen      <= req_wen;
              bus_wdata    <= w_st_wdata;
              bus_wmask    <= w_st_wmask;
            end else begin
              r_state    <= ST_DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= ERR_MISALIGN;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response arriving on the timeout cycle takes priority.
          if (bus_respValid) begin
            r_state      <= ST_DONE;
            bus_reqValid <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= bus_respErr ? ERR_BUS : ERR_NONE;
            resp_rdata   <= (bus_respErr || bus_wen) ? '0 : w_ld_result;
          end else if (w_timeout) begin
            r_state      <= ST_DONE;
            bus_reqValid <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= ERR_TIMEOUT;
            resp_rdata   <= '0;
          end
        end
        ST_DONE: begin
          resp_valid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
